// File: rtl/square_limb_seq.sv
// square_limb_seq -- iterative limb squarer.
//
// Squares a NUM_LIMBS*LIMB_W-bit operand using a single LIMB_W x LIMB_W
// multiplier. The multiplier steps through the upper-triangle limb pairs
// (i,j), i<=j, in row-major order. Each product is doubled when i!=j and is
// added into a 2*NUM_LIMBS*LIMB_W-bit accumulator at bit offset (i+j)*LIMB_W.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready is registered)
//   in_x                  operand; limb k = in_x[k*LIMB_W +: LIMB_W]
//   out_valid/out_ready   result handshake
//   out_sq                full square; held through DONE and after
//
// Optional build macro: SQUARE_LIMB_SEQ_ZERO_SKIP_EN
//   Pairs that involve a zero limb are skipped, so they cost no cycle.

module square_limb_seq #(
   parameter int LIMB_W    = 17,
   parameter int NUM_LIMBS = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_LIMBS*LIMB_W-1:0]     in_x,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [2*NUM_LIMBS*LIMB_W-1:0]   out_sq
);

   localparam int NW = NUM_LIMBS * LIMB_W;
   localparam int AW = 2 * NW;
   localparam int CW = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]          state, state_nxt;
   logic [NW-1:0]       x_q;
   logic [AW-1:0]       acc;
   logic [CW-1:0]       ci, cj;      // current pair
   logic [CW-1:0]       ni, nj;      // next scheduled pair
   logic                has_next;    // another pair remains after the current one
   logic                accept;

   logic [LIMB_W-1:0]   xi, xj;
   logic [2*LIMB_W-1:0] prod;
   logic [2*LIMB_W:0]   term;
   logic [AW-1:0]       addend;

   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign out_sq    = acc;

   // Single shared multiplier working on the latched operand.
   assign xi     = x_q[int'(ci)*LIMB_W +: LIMB_W];
   assign xj     = x_q[int'(cj)*LIMB_W +: LIMB_W];
   assign prod   = (2*LIMB_W)'(xi) * (2*LIMB_W)'(xj);
   assign term   = (ci != cj) ? {prod, 1'b0} : {1'b0, prod};
   assign addend = AW'(term) << ((int'(ci) + int'(cj)) * LIMB_W);

`ifdef SQUARE_LIMB_SEQ_ZERO_SKIP_EN
   logic [NUM_LIMBS-1:0] nz_in, nz_q, nz_sel;

   always_comb begin
      for (int k = 0; k < NUM_LIMBS; k++) nz_in[k] = |in_x[k*LIMB_W +: LIMB_W];
   end

   // In IDLE, search from the start of the schedule using the incoming
   // operand. In BUSY, search strictly after the current pair.
   always_comb begin
      nz_sel   = (state == IDLE) ? nz_in : nz_q;
      has_next = 1'b0;
      ni       = '0;
      nj       = '0;
      for (int i = 0; i < NUM_LIMBS; i++) begin
         for (int j = i; j < NUM_LIMBS; j++) begin
            if (!has_next && nz_sel[i] && nz_sel[j] &&
                (state == IDLE || i > int'(ci) || (i == int'(ci) && j > int'(cj)))) begin
               has_next = 1'b1;
               ni       = CW'(i);
               nj       = CW'(j);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      nz_q <= '0;
      else if (accept) nz_q <= nz_in;
   end
`else
   localparam logic [CW-1:0] LAST = CW'(NUM_LIMBS - 1);

   always_comb begin
      has_next = 1'b1;
      ni       = '0;
      nj       = '0;
      if (state != IDLE) begin
         has_next = !(ci == LAST && cj == LAST);
         if (cj == LAST) begin
            ni = ci + CW'(1);
            nj = ci + CW'(1);
         end else begin
            ni = ci;
            nj = cj + CW'(1);
         end
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = has_next ? BUSY : DONE;
         BUSY:    if (!has_next) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         x_q      <= '0;
         acc      <= '0;
         ci       <= '0;
         cj       <= '0;
      end else begin
         state    <= state_nxt;
         // Registered ready: it rises on the first edge after reset and on the take edge.
         in_ready <= (state_nxt == IDLE);
         case (state)
            IDLE: if (accept) begin
               x_q <= in_x;
               acc <= '0;
               ci  <= ni;
               cj  <= nj;
            end
            BUSY: begin
               acc <= acc + addend;
               if (has_next) begin
                  ci <= ni;
                  cj <= nj;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
